ptw_mem_arbiter: RTL

Shares one memory read port between the instruction-side and load/store-side MMU page-table walkers. Each MMU holds a level request (address + req) until it gets a one-cycle read-data pulse. The arbiter grants one walker at a time, issues a valid/ready read to memory, and routes the response back to the owner. It sits between the IFU/LSU MMU instances and the memory/cache interconnect, and absorbs pipeline flushes so a walk aborted by a redirect never corrupts the other requester.

---
 rtl/ptw_mem_arbiter_pkg.sv | 33 +++
 rtl/ptw_arb_pick.sv | 48 ++++
 rtl/ptw_mem_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ptw_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ptw_mem_arbiter_pkg
// Description : Shared encodings for the page-table-walker memory arbiter:
//               FSM states, grant/owner encodings and a small helper.
//               Round-robin arbitration is enabled with the PTW_ARB_RR_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
package ptw_mem_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    PTW_ARB_IDLE = 2'd0,
    PTW_ARB_REQ  = 2'd1,
    PTW_ARB_RESP = 2'd2,
    PTW_ARB_DROP = 2'd3
  } ptw_arb_state_e;

  // Grant / owner encodings. These are one-hot so they can drive grant_o
  // directly and select the owner's flush with a simple AND-OR.
  localparam logic [1:0] PTW_GNT_NONE = 2'b00;
  localparam logic [1:0] PTW_GNT_IF   = 2'b01;
  localparam logic [1:0] PTW_GNT_LS   = 2'b10;

  // Flush belonging to whichever walker currently owns the port.
  function automatic logic ptw_owner_flush(input logic [1:0] owner,
                                           input logic       if_flush,
                                           input logic       ls_flush);
    return (owner[0] & if_flush) | (owner[1] & ls_flush);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ptw_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : ptw_arb_pick
// Description : Combinational winner select between the IFU and LSU walkers.
//               PTW_ARB_RR_EN defined   : round-robin, tie goes to the walker
//                                         not granted last.
//               PTW_ARB_RR_EN undefined : fixed priority, LS over IF.
// Revision    : 1.0 - initial release
// ============================================================================
module ptw_arb_pick
  import ptw_mem_arbiter_pkg::*;
(
  input  logic       if_elig_i,
  input  logic       ls_elig_i,
  input  logic [1:0] last_grant_i,
  output logic [1:0] grant_o
);

`ifdef PTW_ARB_RR_EN
  // Round-robin: on a tie, hand the port to the walker that did not win last.
  always_comb begin
    grant_o = PTW_GNT_NONE;
    if (if_elig_i && ls_elig_i) begin
      grant_o = (last_grant_i == PTW_GNT_IF) ? PTW_GNT_LS : PTW_GNT_IF;
    end else if (ls_elig_i) begin
      grant_o = PTW_GNT_LS;
    end else if (if_elig_i) begin
      grant_o = PTW_GNT_IF;
    end
  end
`else
  // History is irrelevant under fixed priority.
  logic w_unused_last_grant;
  assign w_unused_last_grant = ^last_grant_i;

  // Fixed priority: LS walks are bounded by pipeline stall, so LS wins ties.
  always_comb begin
    grant_o = PTW_GNT_NONE;
    if (ls_elig_i) begin
      grant_o = PTW_GNT_LS;
    end else if (if_elig_i) begin
      grant_o = PTW_GNT_IF;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/ptw_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ptw_mem_arbiter
// Description : Shares one memory read port between the IFU and LSU MMU
//               page-table walkers. One transaction outstanding at a time;
//               owner flushes abort or drop the in-flight walk without
//               disturbing the other walker.
//               Optional macro PTW_ARB_RR_EN selects round-robin arbitration
//               (default build: fixed priority LS over IF).
// Revision    : 1.0 - initial release
// ============================================================================
module ptw_mem_arbiter
  import ptw_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // IFU walker
  input  logic              if_ptw_req_i,
  input  logic [ADDR_W-1:0] if_ptw_addr_i,
  output logic [DATA_W-1:0] if_ptw_rdata_o,
  output logic              if_ptw_rvalid_o,
  input  logic              if_flush_i,
  // LSU walker
  input  logic              ls_ptw_req_i,
  input  logic [ADDR_W-1:0] ls_ptw_addr_i,
  output logic [DATA_W-1:0] ls_ptw_rdata_o,
  output logic              ls_ptw_rvalid_o,
  input  logic              ls_flush_i,
  // Memory read port
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  // Status
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  ptw_arb_state_e    state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic              w_if_elig;
  logic              w_ls_elig;
  logic [1:0]        w_pick;
  logic [1:0]        w_last_grant;
  logic              w_owner_flush;

  // A flushing walker is never eligible, so an aborted walk cannot restart.
  assign w_if_elig     = if_ptw_req_i & ~if_flush_i;
  assign w_ls_elig     = ls_ptw_req_i & ~ls_flush_i;
  assign w_owner_flush = ptw_owner_flush(owner_q, if_flush_i, ls_flush_i);

  ptw_arb_pick u_pick (
    .if_elig_i    (w_if_elig),
    .ls_elig_i    (w_ls_elig),
    .last_grant_i (w_last_grant),
    .grant_o      (w_pick)
  );

`ifdef PTW_ARB_RR_EN
  logic [1:0] last_grant_q;

  // Remember every grant, including ones later aborted by a flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= PTW_GNT_IF;
    end else if ((state_q == PTW_ARB_IDLE) && (w_pick != PTW_GNT_NONE)) begin
      last_grant_q <= w_pick;
    end
  end

  assign w_last_grant = last_grant_q;
`else
  assign w_last_grant = PTW_GNT_IF;
`endif

  // Next-state and response routing; flush of the owner always wins.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;

    case (state_q)
      PTW_ARB_IDLE: begin
        // Stray mem_rvalid_i here (e.g. after a reset mid-walk) is ignored.
        if (w_pick != PTW_GNT_NONE) begin
          owner_d = w_pick;
          addr_d  = (w_pick == PTW_GNT_LS) ? ls_ptw_addr_i : if_ptw_addr_i;
          state_d = PTW_ARB_REQ;
        end
      end

      PTW_ARB_REQ: begin
        if (mem_ready_i) begin
          state_d = w_owner_flush ? PTW_ARB_DROP : PTW_ARB_RESP;
        end else if (w_owner_flush) begin
          // Nothing was accepted, so the walk can be abandoned outright.
          state_d = PTW_ARB_IDLE;
          owner_d = PTW_GNT_NONE;
        end
      end

      PTW_ARB_RESP: begin
        if (w_owner_flush) begin
          if (mem_rvalid_i) begin
            state_d = PTW_ARB_IDLE;
            owner_d = PTW_GNT_NONE;
          end else begin
            state_d = PTW_ARB_DROP;
          end
        end else if (mem_rvalid_i) begin
          if (owner_q == PTW_GNT_LS) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = mem_rdata_i;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
          state_d = PTW_ARB_IDLE;
          owner_d = PTW_GNT_NONE;
        end
      end

      PTW_ARB_DROP: begin
        // Swallow the response of the flushed walk.
        if (mem_rvalid_i) begin
          state_d = PTW_ARB_IDLE;
          owner_d = PTW_GNT_NONE;
        end
      end

      default: begin
        state_d = PTW_ARB_IDLE;
        owner_d = PTW_GNT_NONE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight walk silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PTW_ARB_IDLE;
      owner_q     <= PTW_GNT_NONE;
      addr_q      <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  // All outputs come straight from registers: no req-to-mem combinational path.
  assign mem_req_o       = (state_q == PTW_ARB_REQ);
  assign mem_addr_o      = addr_q;
  assign grant_o         = owner_q;
  assign busy_o          = (state_q != PTW_ARB_IDLE);
  assign if_ptw_rvalid_o = if_rvalid_q;
  assign ls_ptw_rvalid_o = ls_rvalid_q;
  assign if_ptw_rdata_o  = if_rdata_q;
  assign ls_ptw_rdata_o  = ls_rdata_q;

endmodule
`default_nettype wire
